regfile_wb_arbiter: RTL and testbench

Write-back scheduler for the 32x64b integer register file.
- Shares the file's single write port (we/wa/wd) between NREQ producers (ALU, load unit, CSR/mul-div) using round-robin arbitration and a valid/ready handshake.
- Keeps a busy scoreboard of registers with writes in flight, so the issue stage can detect RAW hazards on its two read addresses.
- Sits between the execute-side producers and the regfile write port.

---
 rtl/regfile_wb_arbiter_pkg.sv | 23 ++
 rtl/regfile_wb_arbiter_if.sv | 38 +++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 116 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
// The requester index constants name the fixed producer slots on the write port.
package regfile_wb_arbiter_pkg;

    localparam int XLEN  = 64;
    localparam int AW    = 5;
    localparam int NREGS = 32;

    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_CSR = 2;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

    // Round-robin successor of index g among n slots.
    function automatic int rr_next(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bus from the producers plus the regfile write port.
// The master side is the producer/regfile environment; the slave side is the scheduler.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ = 3
) ();

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;

    logic                 rf_we;
    logic [AW-1:0]        rf_wa;
    logic [XLEN-1:0]      rf_wd;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready,
        input  rf_we,
        input  rf_wa,
        input  rf_wd
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready,
        output rf_we,
        output rf_wa,
        output rf_wd
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and wraps modulo N,
// granting the first requesting index. The grant is one-hot, or zero when nobody requests.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin : g_search
            int idx;
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back scheduler: round-robin sharing of the single regfile write port among
// NREQ producers, plus the busy scoreboard the issue stage uses for RAW detection.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus,
    input  logic                 sb_set_i,
    input  logic [AW-1:0]        sb_set_addr_i,
    input  logic [AW-1:0]        ra1_i,
    input  logic [AW-1:0]        ra2_i,
    output logic                 hazard1_o,
    output logic                 hazard2_o,
    output logic [NREGS-1:0]     busy_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    wb_req_t          req_s [NREQ];
    logic [NREQ-1:0]  gnt;
    wb_req_t          sel_req;
    logic [PW-1:0]    g_idx;
    logic             xfer;

    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             rf_we_q, rf_we_d;
    logic [AW-1:0]    rf_wa_q, rf_wa_d;
    logic [XLEN-1:0]  rf_wd_q, rf_wd_d;
    logic [NREGS-1:0] busy_q, busy_d;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_s[gi].addr = bus.req_addr[gi*AW +: AW];
            assign req_s[gi].data = bus.req_data[gi*XLEN +: XLEN];
        end
    endgenerate

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr_arbiter (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt)
    );

    // Grants are suppressed while reset is held so no producer sees a phantom transfer.
    assign bus.req_ready = rst_n ? gnt : '0;

    always_comb begin
        sel_req = '0;
        g_idx   = '0;
        xfer    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_req = req_s[i];
                g_idx   = PW'(i);
                xfer    = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        rf_we_d  = 1'b0;
        rf_wa_d  = rf_wa_q;
        rf_wd_d  = rf_wd_q;
        if (xfer) begin
            rr_ptr_d = PW'(rr_next(int'(g_idx), NREQ));
            // An x0 destination still consumes the slot but never writes the file.
            rf_we_d  = (sel_req.addr != '0);
            rf_wa_d  = sel_req.addr;
            rf_wd_d  = sel_req.data;
        end
    end

    // Clear first, then set: a fresh reservation on the register being retired must survive.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_wa_q] = 1'b0;
        end
        if (sb_set_i && (sb_set_addr_i != '0)) begin
            busy_d[sb_set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            rf_we_q  <= 1'b0;
            rf_wa_q  <= '0;
            rf_wd_q  <= '0;
            busy_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rf_we_q  <= rf_we_d;
            rf_wa_q  <= rf_wa_d;
            rf_wd_q  <= rf_wd_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.rf_we = rf_we_q;
    assign bus.rf_wa = rf_wa_q;
    assign bus.rf_wd = rf_wd_q;
    assign busy_o    = busy_q;

    assign hazard1_o = rst_n && (ra1_i != '0) && busy_q[ra1_i];
    assign hazard2_o = rst_n && (ra2_i != '0) && busy_q[ra2_i];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for the write-back scheduler, using a queue-based
// scoreboard for regfile writes and a cycle-level reference model for grants and busy bits.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int NREQ = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NREQ(NREQ)) bus ();

    logic             sb_set;
    logic [AW-1:0]    sb_set_addr, ra1, ra2;
    logic             hazard1, hazard2;
    logic [NREGS-1:0] busy;

    regfile_wb_arbiter #(.NREQ(NREQ)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .sb_set_i      (sb_set),
        .sb_set_addr_i (sb_set_addr),
        .ra1_i         (ra1),
        .ra2_i         (ra2),
        .hazard1_o     (hazard1),
        .hazard2_o     (hazard2),
        .busy_o        (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Stimulus for the next cycle.
    logic [NREQ-1:0] drv_valid;
    logic [AW-1:0]   drv_addr [NREQ];
    logic [XLEN-1:0] drv_data [NREQ];
    logic            drv_sb;
    logic [AW-1:0]   drv_sb_addr, drv_ra1, drv_ra2;

    // Reference model state.
    int               m_ptr;
    logic [NREGS-1:0] m_busy;
    bit               m_pend;
    logic [AW-1:0]    m_pend_addr;
    wb_req_t          exp_q [$];
    int               wait_cnt [NREQ];
    int               last_grant;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_busy = '0;
        m_pend = 1'b0;
        m_pend_addr = '0;
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    endtask

    task automatic clear_drv();
        drv_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            drv_addr[i] = '0;
            drv_data[i] = '0;
        end
        drv_sb      = 1'b0;
        drv_sb_addr = '0;
        drv_ra1     = '0;
        drv_ra2     = '0;
    endtask

    // One clock cycle: drive, predict, check at negedge, then advance the model past the next edge.
    task automatic step();
        int g;
        logic [NREQ-1:0] exp_rdy;
        logic h1e, h2e;
        @(posedge clk);
        #1;
        bus.req_valid = drv_valid;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*AW +: AW]     = drv_addr[i];
            bus.req_data[i*XLEN +: XLEN] = drv_data[i];
        end
        sb_set      = drv_sb;
        sb_set_addr = drv_sb_addr;
        ra1         = drv_ra1;
        ra2         = drv_ra2;

        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && drv_valid[idx]) g = idx;
        end
        exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
        h1e = m_busy[drv_ra1] && (drv_ra1 != '0);
        h2e = m_busy[drv_ra2] && (drv_ra2 != '0);

        @(negedge clk);
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("rf_we", 64'(bus.rf_we), 64'(m_pend));
        chk("hazard1", 64'(hazard1), 64'(h1e));
        chk("hazard2", 64'(hazard2), 64'(h2e));

        for (int i = 0; i < NREQ; i++) begin
            if (i == g) begin
                chk("starvation_bound", 64'(wait_cnt[i] < NREQ), 64'(1));
                wait_cnt[i] = 0;
            end else if (drv_valid[i]) begin
                wait_cnt[i]++;
            end else begin
                wait_cnt[i] = 0;
            end
        end

        if (m_pend) m_busy[m_pend_addr] = 1'b0;
        if (drv_sb && drv_sb_addr != '0) m_busy[drv_sb_addr] = 1'b1;
        m_pend = 1'b0;
        if (g >= 0) begin
            if (drv_addr[g] != '0) begin
                exp_q.push_back('{addr: drv_addr[g], data: drv_data[g]});
                m_pend      = 1'b1;
                m_pend_addr = drv_addr[g];
            end
            m_ptr = (g + 1) % NREQ;
        end
        last_grant = g;
    endtask

    // Monitor: every regfile write must match the oldest outstanding accepted request.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rf_write: unexpected write wa=%h wd=%h", bus.rf_wa, bus.rf_wd);
                end else begin
                    wb_req_t e;
                    e = exp_q.pop_front();
                    chk("rf_wa", 64'(bus.rf_wa), 64'(e.addr));
                    chk("rf_wd", 64'(bus.rf_wd), 64'(e.data));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        sb_set = 1'b0; sb_set_addr = '0; ra1 = '0; ra2 = '0;
        clear_drv();
        model_reset();
        last_grant = -1;
        #2 rst_n = 1'b0;

        // Reset holds everything quiet even with all requesters valid.
        bus.req_valid = '1;
        bus.req_addr  = {5'd3, 5'd2, 5'd1};
        ra1 = 5'd1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
            chk("rst_rf_we", 64'(bus.rf_we), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
        end
        chk("rst_rf_wa", 64'(bus.rf_wa), 64'(0));
        chk("rst_rf_wd", 64'(bus.rf_wd), 64'(0));
        bus.req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single write to x5 with a hazard window on ra1.
        clear_drv();
        drv_sb = 1'b1; drv_sb_addr = 5'd5; drv_ra1 = 5'd5;
        step();
        drv_sb = 1'b0;
        drv_valid[WB_ALU] = 1'b1; drv_addr[WB_ALU] = 5'd5; drv_data[WB_ALU] = 64'hDEAD_BEEF;
        step();
        chk("single_grant", 64'(last_grant), 64'(WB_ALU));
        chk("single_hazard", 64'(hazard1), 64'(1));
        drv_valid = '0;
        step();
        chk("single_we", 64'(bus.rf_we), 64'(1));
        chk("single_wd", 64'(bus.rf_wd), 64'hDEAD_BEEF);
        step();
        chk("single_hazard_drop", 64'(hazard1), 64'(0));

        // Contention: the pointer sits at 1 after the grant to requester 0.
        clear_drv();
        drv_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            drv_addr[i] = AW'(i + 1);
            drv_data[i] = {$urandom, $urandom};
        end
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_order", 64'(last_grant), 64'((1 + k) % NREQ));
        end

        // Fairness: req0 always valid, req2 toggling, req1 idle.
        clear_drv();
        drv_addr[0] = 5'd10; drv_data[0] = 64'h1111;
        drv_addr[2] = 5'd12; drv_data[2] = 64'h2222;
        for (int k = 0; k < 12; k++) begin
            drv_valid[0] = 1'b1;
            drv_valid[2] = (k % 2 == 0);
            step();
            chk("req1_never", 64'(last_grant == 1), 64'(0));
        end

        // x0 request consumes the slot without writing.
        clear_drv();
        drv_valid[WB_LSU] = 1'b1; drv_addr[WB_LSU] = 5'd0; drv_data[WB_LSU] = 64'h5555;
        step();
        chk("x0_grant", 64'(last_grant), 64'(WB_LSU));
        clear_drv();
        step();
        chk("x0_no_we", 64'(bus.rf_we), 64'(0));

        // Collision: write completing on x7 while x7 is reserved again.
        clear_drv();
        drv_sb = 1'b1; drv_sb_addr = 5'd7;
        step();
        clear_drv();
        drv_valid[WB_CSR] = 1'b1; drv_addr[WB_CSR] = 5'd7; drv_data[WB_CSR] = 64'h7777;
        step();
        clear_drv();
        drv_sb = 1'b1; drv_sb_addr = 5'd7;
        step();
        clear_drv();
        step();
        chk("collide_busy7", 64'(busy[7]), 64'(1));

        // Randomized traffic with held requests.
        clear_drv();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!drv_valid[i] && $urandom_range(1, 0) == 1) begin
                    drv_valid[i] = 1'b1;
                    drv_addr[i]  = ($urandom_range(7, 0) == 0) ? '0 : AW'($urandom_range(31, 1));
                    drv_data[i]  = {$urandom, $urandom};
                end
            end
            drv_sb      = ($urandom_range(2, 0) == 0);
            drv_sb_addr = AW'($urandom_range(31, 0));
            drv_ra1     = AW'($urandom_range(31, 0));
            drv_ra2     = AW'($urandom_range(31, 0));
            step();
            if (last_grant >= 0) drv_valid[last_grant] = 1'b0;
        end

        // Reset during a pending write.
        clear_drv();
        drv_sb = 1'b1; drv_sb_addr = 5'd9; drv_ra1 = 5'd9;
        step();
        drv_sb = 1'b0;
        drv_valid[0] = 1'b1; drv_addr[0] = 5'd9; drv_data[0] = 64'h9999;
        step();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_rf_we", 64'(bus.rf_we), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_ready", 64'(bus.req_ready), 64'(0));
        chk("midrst_hazard", 64'(hazard1), 64'(0));
        bus.req_valid = '0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_drv();
        drv_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            drv_addr[i] = AW'(20 + i);
            drv_data[i] = {$urandom, $urandom};
        end
        step();
        chk("post_rst_ptr", 64'(last_grant), 64'(0));

        clear_drv();
        for (int c = 0; c < 3; c++) step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
